xfer_sched: RTL and testbench

Transfer scheduler on the `clock_fpga` side of the transfer buffer. It queues TBM destination addresses for host-filled rx slots (write-drain) and TBM source addresses for host read requests (read-fill). It arbitrates between the two queues and issues one 4 KB slot transfer at a time by driving the buffer's `xfer_buf_select`, `mwrite_enable` and `tbm_address`. It waits for `xfer_complete`, and it can detect a stalled transfer.

---
 rtl/xfer_pkg.sv | 20 ++
 rtl/xfer_addr_fifo.sv | 48 ++++
 rtl/xfer_sched.sv | 148 ++++++++++++++
 tb/tb_xfer_sched.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xfer_pkg.sv
// Shared encodings for the transfer scheduler: FSM states, grant sides, slot geometry.
package xfer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_HALT  = 3'd4
  } xfer_state_t;

  typedef enum logic {
    GNT_RD = 1'b0,
    GNT_WR = 1'b1
  } gnt_t;

  localparam int unsigned SLOT_BYTES      = 4096;
  localparam int unsigned XFER_ALIGN_BITS = 5;

endpackage

// File: rtl/xfer_addr_fifo.sv
// Synchronous address FIFO; head is combinational, push on full is accepted only alongside a pop.
module xfer_addr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign pop_ok  = pop && (level != '0);
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      level <= level + 1'b1;
      else if (pop_ok && !push_ok) level <= level - 1'b1;
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/xfer_sched.sv
// Round-robin scheduler issuing one slot transfer at a time between write-drain and read-fill queues.
// Optional stall detection and HALT state built when XFER_SCHED_TIMEOUT_EN is defined.
module xfer_sched
  import xfer_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int QDEPTH         = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clock_fpga,
  input  logic                       reset,
  input  logic                       wr_push,
  input  logic [ADDRESS_WIDTH-1:0]   wr_address,
  output logic                       wr_ready,
  input  logic                       rd_push,
  input  logic [ADDRESS_WIDTH-1:0]   rd_address,
  output logic                       rd_ready,
  output logic                       xfer_buf_select,
  output logic                       mwrite_enable,
  output logic [ADDRESS_WIDTH-1:0]   tbm_address,
  input  logic                       xfer_complete,
  output logic                       done_wr,
  output logic                       done_rd,
  output logic                       busy,
  output logic                       timeout_err,
  input  logic                       clear_err,
  output logic [$clog2(QDEPTH):0]    wr_level,
  output logic [$clog2(QDEPTH):0]    rd_level
);

  xfer_state_t              state, state_d;
  gnt_t                     grant, grant_d, last_grant;
  logic [ADDRESS_WIDTH-1:0] addr_q, wr_head, rd_head, wr_aligned, rd_aligned;
  logic                     wr_full, rd_full, wr_ne, rd_ne;
  logic                     pop_wr, pop_rd, load_addr, err_set, err_clr, retry, tmo_hit;
  logic                     unused_addr_lsbs;

  assign wr_aligned = {wr_address[ADDRESS_WIDTH-1:XFER_ALIGN_BITS], {XFER_ALIGN_BITS{1'b0}}};
  assign rd_aligned = {rd_address[ADDRESS_WIDTH-1:XFER_ALIGN_BITS], {XFER_ALIGN_BITS{1'b0}}};
  assign unused_addr_lsbs = ^{wr_address[XFER_ALIGN_BITS-1:0], rd_address[XFER_ALIGN_BITS-1:0]};

  xfer_addr_fifo #(.WIDTH(ADDRESS_WIDTH), .DEPTH(QDEPTH)) u_wr_fifo (
    .clk(clock_fpga), .rst_n(reset), .push(wr_push), .push_data(wr_aligned),
    .pop(pop_wr), .head(wr_head), .level(wr_level), .full(wr_full)
  );

  xfer_addr_fifo #(.WIDTH(ADDRESS_WIDTH), .DEPTH(QDEPTH)) u_rd_fifo (
    .clk(clock_fpga), .rst_n(reset), .push(rd_push), .push_data(rd_aligned),
    .pop(pop_rd), .head(rd_head), .level(rd_level), .full(rd_full)
  );

  assign wr_ready = !wr_full;
  assign rd_ready = !rd_full;
  assign wr_ne    = (wr_level != '0);
  assign rd_ne    = (rd_level != '0);

`ifdef XFER_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  always_ff @(posedge clock_fpga or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;
      if (err_set)      err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
    end
  end

  assign tmo_hit     = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = err_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d   = state;
    grant_d   = grant;
    load_addr = 1'b0;
    pop_wr    = 1'b0;
    pop_rd    = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wr_ne || rd_ne) begin
          state_d   = ST_ISSUE;
          load_addr = 1'b1;
          // A retry after HALT must reissue the stalled entry, not re-arbitrate.
          if (retry)               grant_d = grant;
          else if (wr_ne && rd_ne) grant_d = (last_grant == GNT_RD) ? GNT_WR : GNT_RD;
          else                     grant_d = wr_ne ? GNT_WR : GNT_RD;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (xfer_complete) begin
          state_d = ST_DONE;
        end else if (tmo_hit) begin
          state_d = ST_HALT;
          err_set = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        pop_wr  = (grant == GNT_WR);
        pop_rd  = (grant == GNT_RD);
      end
      ST_HALT: begin
        if (clear_err) begin
          state_d = ST_IDLE;
          err_clr = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_fpga or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      grant      <= GNT_RD;
      last_grant <= GNT_RD;
      addr_q     <= '0;
      retry      <= 1'b0;
    end else begin
      state <= state_d;
      grant <= grant_d;
      if (load_addr)        addr_q <= (grant_d == GNT_WR) ? wr_head : rd_head;
      if (state == ST_DONE) last_grant <= grant;
      if (err_clr)          retry <= 1'b1;
      else if (load_addr)   retry <= 1'b0;
    end
  end

  assign xfer_buf_select = (state == ST_ISSUE);
  assign mwrite_enable   = (state == ST_ISSUE) && (grant == GNT_WR);
  assign tbm_address     = addr_q;
  assign done_wr         = (state == ST_DONE) && (grant == GNT_WR);
  assign done_rd         = (state == ST_DONE) && (grant == GNT_RD);
  assign busy            = (state != ST_IDLE);

endmodule

// File: tb/tb_xfer_sched.sv
// Randomized bench for xfer_sched against a transaction-level queue model with cycle timing rules.
module tb_xfer_sched;

  localparam int QD = 4;
  localparam int TO = 16;
`ifdef XFER_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_push = 1'b0, rd_push = 1'b0, xfer_complete = 1'b0, clear_err = 1'b0;
  logic [31:0] wr_address = '0, rd_address = '0;
  logic        wr_ready, rd_ready, xfer_buf_select, mwrite_enable;
  logic        done_wr, done_rd, busy, timeout_err;
  logic [31:0] tbm_address;
  logic [2:0]  wr_level, rd_level;

  always #5 clk = ~clk;

  xfer_sched #(.ADDRESS_WIDTH(32), .QDEPTH(QD), .TIMEOUT_CYCLES(TO)) dut (
    .clock_fpga(clk), .reset(rst_n),
    .wr_push(wr_push), .wr_address(wr_address), .wr_ready(wr_ready),
    .rd_push(rd_push), .rd_address(rd_address), .rd_ready(rd_ready),
    .xfer_buf_select(xfer_buf_select), .mwrite_enable(mwrite_enable), .tbm_address(tbm_address),
    .xfer_complete(xfer_complete), .done_wr(done_wr), .done_rd(done_rd), .busy(busy),
    .timeout_err(timeout_err), .clear_err(clear_err), .wr_level(wr_level), .rd_level(rd_level)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending addresses per side plus timing of the one outstanding transfer.
  bit [31:0] wq[$], rq[$], issued[$];
  bit        m_last_g, m_g, m_busy, m_halt, m_err, m_retry;
  bit [31:0] m_addr;
  int        cyc, issue_at, done_at, wait_n, dly, fixed_dly;
  bit        auto_cpl = 1'b1, spur_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    wq.delete(); rq.delete();
    m_last_g = 1'b0; m_g = 1'b0; m_busy = 1'b0; m_halt = 1'b0; m_err = 1'b0; m_retry = 1'b0;
    m_addr = '0; issue_at = -10; done_at = -1; wait_n = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wr_push = 1'b0; rd_push = 1'b0; xfer_complete = 1'b0; clear_err = 1'b0;
    #1;
    chk("rst_strobe", xfer_buf_select, 0);
    chk("rst_mwrite", mwrite_enable, 0);
    chk("rst_tbm", tbm_address, 0);
    chk("rst_done", {done_wr, done_rd}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_ready", {wr_ready, rd_ready}, 2'b11);
    chk("rst_levels", {wr_level, rd_level}, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic tick();
    bit g, waiting;
    @(posedge clk);
    if (m_busy && cyc == done_at) begin
      if (m_g) void'(wq.pop_front()); else void'(rq.pop_front());
      m_last_g = m_g;
      m_busy   = 1'b0;
    end else if (m_busy && m_halt) begin
      if (clear_err) begin
        m_halt = 1'b0; m_err = 1'b0; m_retry = 1'b1; m_busy = 1'b0;
      end
    end else if (m_busy && cyc > issue_at && done_at < 0) begin
      if (xfer_complete) done_at = cyc + 1;
      else begin
        wait_n++;
        if (TO_EN && wait_n == TO) begin m_halt = 1'b1; m_err = 1'b1; end
      end
    end else if (!m_busy && (wq.size() != 0 || rq.size() != 0)) begin
      if (m_retry)                            g = m_g;
      else if (wq.size() != 0 && rq.size() != 0) g = !m_last_g;
      else                                    g = (wq.size() != 0);
      m_retry  = 1'b0;
      m_g      = g;
      m_addr   = g ? wq[0] : rq[0];
      m_busy   = 1'b1;
      issue_at = cyc + 1;
      done_at  = -1;
      wait_n   = 0;
      dly      = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, 8));
    end
    if (wr_push && wq.size() < QD) wq.push_back(wr_address & 32'hFFFF_FFE0);
    if (rd_push && rq.size() < QD) rq.push_back(rd_address & 32'hFFFF_FFE0);
    cyc++;
    #1;
    chk("xfer_buf_select", xfer_buf_select, m_busy && cyc == issue_at);
    chk("mwrite_enable", mwrite_enable, (m_busy && cyc == issue_at) ? m_g : 1'b0);
    chk("tbm_address", tbm_address, m_addr);
    chk("done_wr", done_wr, m_busy && cyc == done_at && m_g);
    chk("done_rd", done_rd, m_busy && cyc == done_at && !m_g);
    chk("busy", busy, m_busy);
    chk("timeout_err", timeout_err, m_err);
    chk("wr_level", wr_level, wq.size());
    chk("rd_level", rd_level, rq.size());
    chk("ready", {wr_ready, rd_ready}, {wq.size() < QD, rq.size() < QD});
    if (xfer_buf_select) issued.push_back(tbm_address);
    waiting = m_busy && !m_halt && done_at < 0 && cyc > issue_at;
    if (waiting) xfer_complete = auto_cpl && (cyc - issue_at >= dly);
    else         xfer_complete = spur_en && ($urandom_range(0, 5) == 0);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((m_busy || wq.size() != 0 || rq.size() != 0) && n < limit) begin
      tick();
      n++;
    end
    chk("drain_bound", n < limit, 1);
  endtask

  initial begin
    int t_issue, t_done, n;
    bit [31:0] exp_order [4];
    exp_order[0] = 32'h1000; exp_order[1] = 32'h8000;
    exp_order[2] = 32'h2000; exp_order[3] = 32'h9000;
    cyc = 0; fixed_dly = 0;
    do_reset();

    // Single write: strobe two edges after push, complete ten cycles later.
    fixed_dly = 10;
    wr_push = 1'b1; wr_address = 32'h0000_1000;
    tick();
    wr_push = 1'b0;
    chk("t1_level", wr_level, 1);
    tick();
    chk("t1_strobe", {xfer_buf_select, mwrite_enable}, 2'b11);
    chk("t1_addr", tbm_address, 32'h1000);
    t_issue = cyc; t_done = 0; n = 0;
    while (!done_wr && n < 40) begin tick(); n++; end
    if (done_wr) t_done = cyc;
    chk("t1_done_lat", t_done - t_issue, 11);
    tick();
    chk("t1_level_end", wr_level, 0);
    fixed_dly = 0;

    // Round-robin order from a fresh reset.
    do_reset();
    issued.delete();
    wr_push = 1'b1; rd_push = 1'b1; wr_address = 32'h1000; rd_address = 32'h8000;
    tick();
    wr_address = 32'h2000; rd_address = 32'h9000;
    tick();
    wr_push = 1'b0; rd_push = 1'b0;
    drain(200);
    chk("rr_count", issued.size(), 4);
    for (int i = 0; i < 4 && i < issued.size(); i++) chk("rr_order", issued[i], exp_order[i]);

    // Overfill the write queue while the head is stalled.
    auto_cpl = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_push = 1'b1; wr_address = 32'h0001_0000 + 32'(i) * 32'h1000;
      tick();
    end
    wr_push = 1'b0;
    chk("full_level", wr_level, 4);
    chk("full_ready", wr_ready, 0);
    auto_cpl = 1'b1;
    drain(200);

    // Low address bits are discarded.
    wr_push = 1'b1; wr_address = 32'h0000_101F;
    tick();
    wr_push = 1'b0;
    tick();
    chk("align_strobe", xfer_buf_select, 1);
    chk("align_addr", tbm_address, 32'h0000_1000);
    drain(100);

    if (TO_EN) begin
      auto_cpl = 1'b0;
      wr_push = 1'b1; wr_address = 32'h3000;
      tick();
      wr_push = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      chk("tmo_err", timeout_err, 1);
      chk("tmo_busy", busy, 1);
      rd_push = 1'b1; rd_address = 32'h7000;
      tick();
      rd_push = 1'b0; clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      chk("tmo_cleared", timeout_err, 0);
      tick();
      chk("tmo_reissue", {xfer_buf_select, mwrite_enable}, 2'b11);
      chk("tmo_addr", tbm_address, 32'h3000);
      auto_cpl = 1'b1;
      drain(200);
    end

    // Random traffic with spurious completions and stray clear_err.
    spur_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      wr_push = ($urandom_range(0, 3) == 0); wr_address = $urandom;
      rd_push = ($urandom_range(0, 3) == 0); rd_address = $urandom;
      clear_err = ($urandom_range(0, 15) == 0);
      tick();
    end
    wr_push = 1'b0; rd_push = 1'b0; clear_err = 1'b0;
    drain(400);
    spur_en = 1'b0;

    // Reset while waiting on a transfer.
    auto_cpl = 1'b0;
    wr_push = 1'b1; wr_address = 32'h5000; rd_push = 1'b1; rd_address = 32'h6000;
    tick();
    wr_push = 1'b0; rd_push = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_busy", busy, 1);
    do_reset();
    auto_cpl = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
